// File: rtl/alu_op_sequencer_if.sv
// Command/response bundle between a requester and the ALU op sequencer.
// master drives commands and observes responses; slave is the sequencer side.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_load;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_error;

    modport master (
        output cmd_valid, cmd_op, cmd_load, cmd_a, cmd_b,
        input  cmd_ready, rsp_valid, rsp_result, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_load, cmd_a, cmd_b,
        output cmd_ready, rsp_valid, rsp_result, rsp_error
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time through the accumulator ALU datapath:
// drives mux/operand/result selects, waits out the latency, returns a one-cycle response.
module alu_op_sequencer #(
    parameter int WIDTH       = 8,
    parameter int ALU_LATENCY = 1,
    parameter int COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               on,
    input  logic               err_clear,
    alu_op_sequencer_if.slave  bus,
    output logic [2:0]         in_selector,
    output logic [WIDTH-1:0]   num1,
    output logic [WIDTH-1:0]   num2,
    output logic [6:0]         out_selector,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_overflow,
    output logic [1:0]         state,
    output logic [COUNT_W-1:0] op_count
);
    typedef enum logic [1:0] {
        OFF       = 2'b00,
        READY     = 2'b01,
        RUN       = 2'b10,
        RUN_ERROR = 2'b11
    } seqState_t;

    localparam logic [2:0] SEL_PERSIST = 3'b001;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_RESET   = 3'b100;
    localparam int         CNT_W       = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LATENCY);

    seqState_t          curState, stateNxt;
    logic [CNT_W-1:0]   runCnt, runCntNxt;
    logic [2:0]         inSel, inSelNxt;
    logic [WIDTH-1:0]   num1Q, num1Nxt, num2Q, num2Nxt;
    logic [6:0]         outSel, outSelNxt;
    logic               cmdReady, cmdReadyNxt;
    logic               rspValid, rspValidNxt;
    logic [WIDTH-1:0]   rspResult, rspResultNxt;
    logic               rspError, rspErrorNxt;
    logic [COUNT_W-1:0] opCount, opCountNxt;
    logic               accept;

    assign accept = bus.cmd_valid & cmdReady;

    always_comb begin
        stateNxt     = curState;
        runCntNxt    = runCnt;
        inSelNxt     = SEL_PERSIST;
        num1Nxt      = num1Q;
        num2Nxt      = num2Q;
        outSelNxt    = outSel;
        cmdReadyNxt  = 1'b0;
        rspValidNxt  = 1'b0;
        rspResultNxt = rspResult;
        rspErrorNxt  = rspError;
        opCountNxt   = opCount;

        // Dropping enable wins over everything, including a completing RUN.
        if (!on) begin
            stateNxt  = OFF;
            inSelNxt  = SEL_RESET;
            outSelNxt = '0;
        end else begin
            case (curState)
                OFF: begin
                    stateNxt    = READY;
                    cmdReadyNxt = 1'b1;
                end
                READY: begin
                    cmdReadyNxt = 1'b1;
                    if (accept) begin
                        cmdReadyNxt = 1'b0;
                        if (bus.cmd_op == 3'd7) begin
                            stateNxt     = RUN_ERROR;
                            rspValidNxt  = 1'b1;
                            rspErrorNxt  = 1'b1;
                            rspResultNxt = '0;
                        end else begin
                            stateNxt  = RUN;
                            runCntNxt = CNT_INIT;
                            inSelNxt  = bus.cmd_load ? SEL_LOAD : SEL_PERSIST;
                            if (bus.cmd_load) num1Nxt = bus.cmd_a;
                            num2Nxt   = bus.cmd_b;
                            outSelNxt = 7'b1 << bus.cmd_op;
                        end
                    end
                end
                RUN: begin
                    if (runCnt == '0) begin
                        rspValidNxt  = 1'b1;
                        rspResultNxt = alu_result;
                        rspErrorNxt  = alu_overflow;
                        outSelNxt    = '0;
                        if (alu_overflow) begin
                            stateNxt = RUN_ERROR;
                        end else begin
                            // Back to READY alongside the response so the next command
                            // can be taken in the response cycle.
                            stateNxt    = READY;
                            cmdReadyNxt = 1'b1;
                            opCountNxt  = opCount + COUNT_W'(1);
                        end
                    end else begin
                        runCntNxt = runCnt - CNT_W'(1);
                    end
                end
                RUN_ERROR: begin
                    if (err_clear) begin
                        stateNxt    = READY;
                        cmdReadyNxt = 1'b1;
                    end
                end
                default: stateNxt = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curState  <= OFF;
            runCnt    <= '0;
            inSel     <= SEL_RESET;
            num1Q     <= '0;
            num2Q     <= '0;
            outSel    <= '0;
            cmdReady  <= 1'b0;
            rspValid  <= 1'b0;
            rspResult <= '0;
            rspError  <= 1'b0;
            opCount   <= '0;
        end else begin
            curState  <= stateNxt;
            runCnt    <= runCntNxt;
            inSel     <= inSelNxt;
            num1Q     <= num1Nxt;
            num2Q     <= num2Nxt;
            outSel    <= outSelNxt;
            cmdReady  <= cmdReadyNxt;
            rspValid  <= rspValidNxt;
            rspResult <= rspResultNxt;
            rspError  <= rspErrorNxt;
            opCount   <= opCountNxt;
        end
    end

    assign state          = curState;
    assign in_selector    = inSel;
    assign num1           = num1Q;
    assign num2           = num2Q;
    assign out_selector   = outSel;
    assign op_count       = opCount;
    assign bus.cmd_ready  = cmdReady;
    assign bus.rsp_valid  = rspValid;
    assign bus.rsp_result = rspResult;
    assign bus.rsp_error  = rspError;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural accumulator datapath
// and an arithmetic reference model of expected responses.
module tb_alu_op_sequencer;
    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       on = 1'b0;
    logic       err_clear = 1'b0;
    logic [2:0] in_selector;
    logic [7:0] num1, num2;
    logic [6:0] out_selector;
    logic [7:0] alu_result;
    logic       alu_overflow;
    logic [1:0] state;
    logic [7:0] op_count;

    alu_op_sequencer_if #(.WIDTH(8)) bus ();

    alu_op_sequencer #(.WIDTH(8), .ALU_LATENCY(LAT), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .on(on), .err_clear(err_clear), .bus(bus),
        .in_selector(in_selector), .num1(num1), .num2(num2), .out_selector(out_selector),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .state(state), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChk = 0, nPass = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Opcode semantics on plain integers: {overflow, 8-bit result}.
    function automatic logic [8:0] refOp(input int op, input int a, input int b);
        int r;
        logic ovf;
        ovf = 1'b0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = (~a) & 255;
            3: r = a ^ b;
            4: begin r = a + b; ovf = (r > 255); end
            5: begin r = a - b; ovf = (r < 0);   end
            6: begin r = a * b; ovf = (r > 255); end
            default: r = 0;
        endcase
        return {ovf, 8'(r & 255)};
    endfunction

    // Datapath stand-in: operand registers captured each edge, combinational result,
    // result fed back into the accumulator once the sequencer releases out_selector.
    logic [7:0] dpAcc, dpB;
    logic [6:0] dpSel;
    always @(posedge clk) begin
        if (in_selector == 3'b100)                       dpAcc <= 8'h00;
        else if (in_selector == 3'b010)                  dpAcc <= num1;
        else if (dpSel != 7'd0 && out_selector == 7'd0)  dpAcc <= alu_result;
        dpB   <= num2;
        dpSel <= out_selector;
    end
    always_comb begin
        logic [8:0] r;
        r = 9'h0;
        for (int i = 0; i < 7; i++)
            if (dpSel == (7'd1 << i)) r = refOp(i, int'(dpAcc), int'(dpB));
        {alu_overflow, alu_result} = r;
    end

    // Reference model and scoreboard
    typedef struct {
        logic [7:0] res;
        logic       err;
        logic [7:0] cnt;
        int         hsCyc;
        int         lat;
    } exp_t;
    exp_t expQ[$];
    exp_t monE;
    int   refAcc = 0;
    int   refCnt = 0;
    bit   lastErr;
    bit   acceptWithRsp;

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            chk("rsp_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                monE = expQ.pop_front();
                chk("rsp_result", 32'(bus.rsp_result), 32'(monE.res));
                chk("rsp_error", 32'(bus.rsp_error), 32'(monE.err));
                chk("op_count_at_rsp", 32'(op_count), 32'(monE.cnt));
                chk("rsp_latency", 32'(cyc - monE.hsCyc), 32'(monE.lat));
                chk("state_at_rsp", 32'(state), monE.err ? 32'd3 : 32'd1);
                chk("cmd_ready_at_rsp", 32'(bus.cmd_ready), monE.err ? 32'd0 : 32'd1);
            end
        end
    end

    task automatic sendCmd(input int op, input bit load, input int a, input int b, input bit expRsp);
        int   w;
        exp_t e;
        logic [8:0] r;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'(op);
        bus.cmd_load  = load;
        bus.cmd_a     = 8'(a);
        bus.cmd_b     = 8'(b);
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        if (bus.cmd_ready !== 1'b1) begin
            chk("accept_timeout", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        acceptWithRsp = bus.rsp_valid;
        if (expRsp) begin
            if (op == 7) begin
                e.res = 8'h00; e.err = 1'b1; e.lat = 1;
            end else begin
                r = refOp(op, load ? a : refAcc, b);
                refAcc = int'(r[7:0]);
                if (!r[8]) refCnt = (refCnt + 1) & 255;
                e.res = r[7:0]; e.err = r[8]; e.lat = LAT + 2;
            end
            e.cnt   = 8'(refCnt);
            e.hsCyc = cyc;
            lastErr = e.err;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (expQ.size() != 0 && w < 50) begin @(negedge clk); w++; end
        chk("drain_queue", 32'(expQ.size()), 32'd0);
    endtask

    task automatic clearErr();
        int w = 0;
        @(negedge clk);
        while (state != 2'b11 && w < 20) begin @(negedge clk); w++; end
        chk("err_state", 32'(state), 32'd3);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("err_cleared_ready", 32'(state), 32'd1);
    endtask

    task automatic chkResetVals(input string tag);
        chk({tag, "_in_sel"}, 32'(in_selector), 32'h4);
        chk({tag, "_nums"}, 32'({num1, num2}), 32'h0);
        chk({tag, "_out_sel"}, 32'(out_selector), 32'h0);
        chk({tag, "_ready_rsp"}, 32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_error}), 32'h0);
        chk({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'h0);
        chk({tag, "_state_cnt"}, 32'({state, op_count}), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_load = 1'b0;
        bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chkResetVals("reset");

        @(negedge clk);
        rst = 1'b0;
        rst = 1'b1;
        on  = 1'b1;
        chk("off_before_edge", 32'(state), 32'd0);
        @(negedge clk);
        chk("ready_state", 32'(state), 32'd1);
        chk("ready_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("ready_in_sel", 32'(in_selector), 32'h1);

        // ADD with load, then back-to-back SUB accumulating on the result
        sendCmd(4, 1'b1, 8'h05, 8'h03, 1'b1);
        @(negedge clk);
        chk("add_in_sel", 32'(in_selector), 32'h2);
        chk("add_out_sel", 32'(out_selector), 32'h10);
        chk("add_operands", 32'({num1, num2}), 32'h0503);
        sendCmd(5, 1'b0, 0, 8'h02, 1'b1);
        chk("b2b_accept_in_rsp_cycle", 32'(acceptWithRsp), 32'd1);
        @(negedge clk);
        chk("sub_in_sel", 32'(in_selector), 32'h1);
        chk("sub_out_sel", 32'(out_selector), 32'h20);
        drain();

        // MULT overflow with cmd_valid held through RUN_ERROR
        sendCmd(6, 1'b1, 8'h20, 8'h10, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        drain();
        repeat (3) begin
            @(negedge clk);
            chk("runerr_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("runerr_out_sel", 32'(out_selector), 32'h0);
        end
        bus.cmd_valid = 1'b0;
        clearErr();
        chk("ovf_op_count_kept", 32'(op_count), 32'(refCnt));

        // Illegal opcode
        sendCmd(7, 1'b0, 0, 0, 1'b1);
        @(negedge clk);
        chk("illegal_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("illegal_out_sel", 32'(out_selector), 32'h0);
        chk("illegal_in_sel", 32'(in_selector), 32'h1);
        clearErr();
        drain();

        // Abort by dropping enable during the first RUN cycle
        sendCmd(4, 1'b1, 8'h11, 8'h22, 1'b0);
        on = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_in_sel", 32'(in_selector), 32'h4);
        chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("abort_out_sel", 32'(out_selector), 32'h0);
        refAcc = 0;
        repeat (3) @(negedge clk);
        on = 1'b1;
        @(negedge clk);
        chk("abort_ready_again", 32'(state), 32'd1);

        // Async reset mid-RUN, checked before any clock edge
        sendCmd(4, 1'b1, 8'h01, 8'h01, 1'b0);
        #2 rst = 1'b0;
        #1 chkResetVals("async_reset");
        refAcc = 0;
        refCnt = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(state), 32'd1);

        // Randomized command stream
        for (int n = 0; n < 150; n++) begin
            int op;
            op = int'($urandom_range(0, 7));
            sendCmd(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), 1'b1);
            if (lastErr) clearErr();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        chk("final_op_count", 32'(op_count), 32'(refCnt));

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
